// File: rtl/processor.sv
// processor: single-cycle MIPS-subset core (add/sub/and/or/slt, addi, lw, sw, beq, j).
// Defining PROC_SHIFT_EN adds sll/srl (rd = rt shifted by shamt).
module processor (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instruction,
  input  logic [31:0] mem_data_in,
  output logic [4:0]  written_reg_address,
  output logic [31:0] written_reg_data,
  output logic [31:0] inst_addr,
  output logic [31:0] data_addr,
  output logic [31:0] mem_data_out,
  output logic        mem_read,
  output logic        mem_write
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;
`ifdef PROC_SHIFT_EN
  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
`endif

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_SLL, ALU_SRL
  } aluOpT;

  typedef enum logic [1:0] {WB_NONE, WB_ALU, WB_MEM} wbSelT;
  typedef enum logic [1:0] {PC_SEQ, PC_BRANCH, PC_JUMP} pcSelT;

  logic [31:0] pc;
  logic [31:0] regFile [32];

  logic [5:0]  opcode;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  shamt;
  logic [5:0]  funct;
  logic [25:0] jumpTarget;

  logic signed [31:0] immExt;
  logic signed [31:0] rsVal;
  logic signed [31:0] rtVal;
  logic signed [31:0] aluB;
  logic [31:0]        aluResult;

  aluOpT aluOp;
  wbSelT wbSel;
  pcSelT pcSel;
  logic  aluSrcImm;
  logic  wbToRt;
  logic  isLoad;
  logic  isStore;

  logic [4:0]  wrIdx;
  logic [31:0] wrData;
  logic        regWrEn;
  logic [31:0] pcPlus4;
  logic [31:0] branchOffset;
  logic        branchTaken;
  logic [31:0] nextPc;

  // Shift amount only matters for the shift ops; slt is a signed compare.
  function automatic logic [31:0] aluCompute(input aluOpT op,
                                             input logic signed [31:0] a,
                                             input logic signed [31:0] b,
                                             input logic [4:0] sh);
    logic [31:0] res;
    case (op)
      ALU_ADD: res = a + b;
      ALU_SUB: res = a - b;
      ALU_AND: res = a & b;
      ALU_OR:  res = a | b;
      ALU_SLT: res = {31'b0, (a < b)};
      ALU_SLL: res = unsigned'(b) << sh;
      ALU_SRL: res = unsigned'(b) >> sh;
      default: res = a + b;
    endcase
    return res;
  endfunction

  assign opcode     = instruction[31:26];
  assign rs         = instruction[25:21];
  assign rt         = instruction[20:16];
  assign rd         = instruction[15:11];
  assign shamt      = instruction[10:6];
  assign funct      = instruction[5:0];
  assign jumpTarget = instruction[25:0];
  assign immExt     = signed'({{16{instruction[15]}}, instruction[15:0]});

  always_comb begin
    aluOp     = ALU_ADD;
    wbSel     = WB_NONE;
    pcSel     = PC_SEQ;
    aluSrcImm = 1'b0;
    wbToRt    = 1'b0;
    isLoad    = 1'b0;
    isStore   = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        wbSel = WB_ALU;
        case (funct)
          FN_ADD: aluOp = ALU_ADD;
          FN_SUB: aluOp = ALU_SUB;
          FN_AND: aluOp = ALU_AND;
          FN_OR:  aluOp = ALU_OR;
          FN_SLT: aluOp = ALU_SLT;
`ifdef PROC_SHIFT_EN
          FN_SLL: aluOp = ALU_SLL;
          FN_SRL: aluOp = ALU_SRL;
`endif
          default: wbSel = WB_NONE;
        endcase
      end
      OP_ADDI: begin
        aluSrcImm = 1'b1;
        wbToRt    = 1'b1;
        wbSel     = WB_ALU;
      end
      OP_LW: begin
        aluSrcImm = 1'b1;
        wbToRt    = 1'b1;
        wbSel     = WB_MEM;
        isLoad    = 1'b1;
      end
      OP_SW: begin
        aluSrcImm = 1'b1;
        isStore   = 1'b1;
      end
      OP_BEQ: begin
        aluOp = ALU_SUB;
        pcSel = PC_BRANCH;
      end
      OP_J:    pcSel = PC_JUMP;
      default: ;
    endcase
  end

  // Reads return pre-edge contents; $0 is cleared at reset and never written.
  assign rsVal     = signed'(regFile[rs]);
  assign rtVal     = signed'(regFile[rt]);
  assign aluB      = aluSrcImm ? immExt : rtVal;
  assign aluResult = aluCompute(aluOp, rsVal, aluB, shamt);

  assign wrIdx   = wbToRt ? rt : rd;
  assign wrData  = (wbSel == WB_MEM) ? mem_data_in : aluResult;
  assign regWrEn = (wbSel != WB_NONE) && (wrIdx != 5'd0);

  assign pcPlus4      = pc + 32'd4;
  assign branchOffset = {immExt[29:0], 2'b00};
  assign branchTaken  = (pcSel == PC_BRANCH) && (rsVal == rtVal);

  always_comb begin
    nextPc = pcPlus4;
    if (pcSel == PC_JUMP)
      nextPc = {pcPlus4[31:28], jumpTarget, 2'b00};
    else if (branchTaken)
      nextPc = pcPlus4 + branchOffset;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc                  <= '0;
      written_reg_address <= '0;
      written_reg_data    <= '0;
      for (int i = 0; i < 32; i++)
        regFile[i] <= '0;
    end else begin
      pc <= nextPc;
      if (regWrEn) begin
        regFile[wrIdx]      <= wrData;
        written_reg_address <= wrIdx;
        written_reg_data    <= wrData;
      end
    end
  end

  // Strobes are gated by reset so memory is never disturbed while held.
  assign inst_addr    = pc;
  assign data_addr    = aluResult;
  assign mem_data_out = rtVal;
  assign mem_read     = isLoad & ~reset;
  assign mem_write    = isStore & ~reset;

endmodule

// File: tb/tb_processor.sv
// tb_processor: directed and random programs checked against an instruction-level model.
module tb_processor;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] instruction = '0;
  logic [31:0] mem_data_in = '0;
  logic [4:0]  written_reg_address;
  logic [31:0] written_reg_data;
  logic [31:0] inst_addr;
  logic [31:0] data_addr;
  logic [31:0] mem_data_out;
  logic        mem_read;
  logic        mem_write;

  processor dut (
    .clk                 (clk),
    .reset               (reset),
    .instruction         (instruction),
    .mem_data_in         (mem_data_in),
    .written_reg_address (written_reg_address),
    .written_reg_data    (written_reg_data),
    .inst_addr           (inst_addr),
    .data_addr           (data_addr),
    .mem_data_out        (mem_data_out),
    .mem_read            (mem_read),
    .mem_write           (mem_write)
  );

  always #5 clk = ~clk;

  int passCount = 0;
  int checkCount = 0;

  logic [31:0] imem [logic [31:0]];
  logic [31:0] dmem [logic [31:0]];
  logic [31:0] mReg [32];
  logic [31:0] mPc;
  logic [4:0]  mTrA;
  logic [31:0] mTrD;

  logic [31:0] seenDataAddr;
  logic [31:0] seenMemOut;
  logic        seenRead;
  logic        seenWrite;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [31:0] rT(input logic [5:0] fn, input int rs, input int rt, input int rd);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
  endfunction

  function automatic logic [31:0] iT(input logic [5:0] op, input int rs, input int rt, input int imm);
    return {op, 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  function automatic logic [31:0] jT(input int tgt);
    return {6'h02, 26'(tgt)};
  endfunction

  function automatic logic [31:0] fetch(input logic [31:0] a);
    return imem.exists(a) ? imem[a] : 32'h0;
  endfunction

  function automatic logic [31:0] dmemRd(input logic [31:0] a);
    return dmem.exists(a) ? dmem[a] : ~a;
  endfunction

  function automatic logic [31:0] randInstr();
    int sel;
    int rs;
    int rt;
    int rd;
    logic [5:0] fns [5];
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    sel = $urandom_range(0, 10);
    rs  = $urandom_range(0, 7);
    rt  = $urandom_range(0, 7);
    rd  = $urandom_range(0, 7);
    case (sel)
      0, 1, 2, 3: return rT(fns[$urandom_range(0, 4)], rs, rt, rd);
      4:          return iT(6'h08, rs, rt, int'($urandom_range(0, 65535)));
      5:          return iT(6'h23, rs, rt, int'($urandom_range(0, 15)) * 4);
      6:          return iT(6'h2B, rs, rt, int'($urandom_range(0, 15)) * 4);
      7:          return iT(6'h04, rs, rt, int'($urandom_range(0, 6)) - 3);
      8:          return jT(int'($urandom_range(0, 63)));
      9:          return rT(6'h3F, rs, rt, rd);
      default:    return iT(6'h3F, rs, rt, int'($urandom_range(0, 65535)));
    endcase
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 32; i++) mReg[i] = '0;
    mPc  = '0;
    mTrA = '0;
    mTrD = '0;
  endtask

  // Execute one instruction in the model and compare with the DUT around one edge.
  task automatic step();
    logic [31:0] ins;
    logic [31:0] rsV;
    logic [31:0] rtV;
    logic [31:0] immS;
    logic [31:0] nPc;
    logic [31:0] addr;
    logic [31:0] wv;
    logic [4:0]  wi;
    bit wr;
    bit ld;
    bit st;
    ins  = fetch(mPc);
    instruction = ins;
    rsV  = mReg[ins[25:21]];
    rtV  = mReg[ins[20:16]];
    immS = {{16{ins[15]}}, ins[15:0]};
    addr = rsV + immS;
    nPc  = mPc + 32'd4;
    wi   = ins[20:16];
    wv   = '0;
    wr   = 1'b0;
    ld   = 1'b0;
    st   = 1'b0;
    case (ins[31:26])
      6'h00: begin
        wi = ins[15:11];
        wr = 1'b1;
        case (ins[5:0])
          6'h20:   wv = rsV + rtV;
          6'h22:   wv = rsV - rtV;
          6'h24:   wv = rsV & rtV;
          6'h25:   wv = rsV | rtV;
          6'h2A:   wv = ($signed(rsV) < $signed(rtV)) ? 32'd1 : 32'd0;
          default: wr = 1'b0;
        endcase
      end
      6'h08: begin wr = 1'b1; wv = addr; end
      6'h23: begin wr = 1'b1; ld = 1'b1; wv = dmemRd(addr); end
      6'h2B: st = 1'b1;
      6'h04: if (rsV == rtV) nPc = mPc + 32'd4 + (immS << 2);
      6'h02: nPc = {nPc[31:28], ins[25:0], 2'b00};
      default: ;
    endcase
    #1 mem_data_in = dmemRd(addr);
    #1;
    seenDataAddr = data_addr;
    seenMemOut   = mem_data_out;
    seenRead     = mem_read;
    seenWrite    = mem_write;
    check("inst_addr", inst_addr, mPc);
    check("mem_read", {31'b0, mem_read}, {31'b0, ld});
    check("mem_write", {31'b0, mem_write}, {31'b0, st});
    if (ld || st) check("data_addr", data_addr, addr);
    if (st) check("mem_data_out", mem_data_out, rtV);
    @(posedge clk);
    if (st) dmem[addr] = rtV;
    if (wr && wi != 5'd0) begin
      mReg[wi] = wv;
      mTrA     = wi;
      mTrD     = wv;
    end
    mPc = nPc;
    #1;
    check("trace_addr", {27'b0, written_reg_address}, {27'b0, mTrA});
    check("trace_data", written_reg_data, mTrD);
  endtask

  // Reset pulse shorter than a clock period, landing between edges.
  task automatic midReset();
    #1 reset = 1'b1;
    instruction = iT(6'h2B, 1, 1, 0);
    modelReset();
    #1;
    check("rst_inst_addr", inst_addr, 32'h0);
    check("rst_mem_write", {31'b0, mem_write}, 32'h0);
    check("rst_trace_addr", {27'b0, written_reg_address}, 32'h0);
    check("rst_trace_data", written_reg_data, 32'h0);
    #1 reset = 1'b0;
  endtask

  initial begin
    modelReset();
    instruction = iT(6'h23, 0, 1, 0);
    #12;
    check("por_inst_addr", inst_addr, 32'h0);
    check("por_mem_read", {31'b0, mem_read}, 32'h0);
    check("por_mem_write", {31'b0, mem_write}, 32'h0);
    check("por_trace_addr", {27'b0, written_reg_address}, 32'h0);
    check("por_trace_data", written_reg_data, 32'h0);

    imem[32'h00] = 32'h0;
    imem[32'h04] = 32'h0;
    imem[32'h08] = 32'h0;
    imem[32'h0C] = iT(6'h08, 0, 1, 5);
    imem[32'h10] = iT(6'h04, 1, 1, 2);
    imem[32'h14] = iT(6'h08, 0, 7, 99);
    imem[32'h18] = iT(6'h08, 0, 7, 98);
    imem[32'h1C] = iT(6'h08, 0, 2, -3);
    imem[32'h20] = rT(6'h20, 1, 2, 3);
    imem[32'h24] = rT(6'h2A, 2, 1, 4);
    imem[32'h28] = iT(6'h04, 1, 2, 2);
    imem[32'h2C] = iT(6'h2B, 0, 1, 8);
    imem[32'h30] = iT(6'h23, 0, 5, 8);
    imem[32'h34] = iT(6'h08, 0, 0, 7);
    imem[32'h38] = iT(6'h2B, 0, 0, 12);
    imem[32'h3C] = jT(32'h40);
    imem[32'h100] = rT(6'h3F, 1, 2, 6);
    imem[32'h104] = iT(6'h3F, 1, 6, 4);
    imem[32'h108] = rT(6'h22, 1, 2, 7);
    imem[32'h10C] = rT(6'h24, 1, 2, 8);
    imem[32'h110] = rT(6'h25, 1, 2, 9);

    @(posedge clk);
    #1 reset = 1'b0;
    repeat (3) step();
    check("after_3_nops", inst_addr, 32'd12);
    step();
    check("addi1_idx", {27'b0, written_reg_address}, 32'd1);
    check("addi1_val", written_reg_data, 32'd5);
    step();
    check("beq_taken", inst_addr, 32'h1C);
    step();
    check("addi2_val", written_reg_data, 32'hFFFF_FFFD);
    step();
    check("add_val", written_reg_data, 32'd2);
    step();
    check("slt_val", written_reg_data, 32'd1);
    step();
    check("beq_not_taken", inst_addr, 32'h2C);
    step();
    check("sw_strobe", {31'b0, seenWrite}, 32'd1);
    check("sw_addr", seenDataAddr, 32'd8);
    check("sw_data", seenMemOut, 32'd5);
    step();
    check("lw_strobe", {31'b0, seenRead}, 32'd1);
    check("lw_idx", {27'b0, written_reg_address}, 32'd5);
    check("lw_val", written_reg_data, 32'd5);
    step();
    check("r0_no_trace", {27'b0, written_reg_address}, 32'd5);
    step();
    check("r0_reads_zero", seenMemOut, 32'd0);
    step();
    check("jump_target", inst_addr, 32'h100);
    repeat (6) step();

    midReset();
    imem.delete();
    for (int k = 1; k < 10; k++) imem[32'(4 * (k - 1))] = iT(6'h2B, 0, k, 4 * k);
    for (int k = 1; k < 10; k++) begin
      step();
      check("post_reset_reg", seenMemOut, 32'd0);
    end

    midReset();
    imem.delete();
    for (int k = 1; k < 8; k++) imem[32'(4 * (k - 1))] = iT(6'h08, 0, k, int'($urandom_range(0, 65535)));
    for (int k = 7; k < 64; k++) imem[32'(4 * k)] = randInstr();
    imem[32'h100] = jT(0);
    repeat (400) step();

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
